spike_queue_ctrl: RTL and testbench

SPIKE_QUEUE_CTRL -- requirements
Module: spike_queue_ctrl

---
 rtl/spike_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/spike_queue_ctrl.sv | 144 ++++++++++++++
 tb/tb_spike_queue_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_pkg
// Description : Shared widths, queue-entry layout and dequeue FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spike_pkg;

  localparam int unsigned c_val_w_def  = 16;
  localparam int unsigned c_life_w_def = 16;

  typedef struct packed {
    logic [c_val_w_def-1:0]  val;
    logic [c_life_w_def-1:0] life;
  } spike_entry_t;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_fetch = 2'd1;
  localparam state_t c_st_hold  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : One-hot round-robin pick, searching upward from the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic             w_found;
  int               w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_idx = PTR_W'(w_sum);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spike_queue_ctrl
// Description : Arbitrates spike requesters into an external fifo, delivers the
//               head with decremented life and recirculates it while alive.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_queue_ctrl
  import spike_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int VAL_W  = c_val_w_def,
  parameter int LIFE_W = c_life_w_def
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*VAL_W-1:0]   req_val,
  input  logic [NREQ*LIFE_W-1:0]  req_life,
  output logic [NREQ-1:0]         gnt,
  output logic                    q_enq,
  output logic                    q_deq,
  output logic [VAL_W+LIFE_W-1:0] q_din,
  input  logic [VAL_W+LIFE_W-1:0] q_dout,
  input  logic                    q_full,
  input  logic                    q_empty,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VAL_W-1:0]        out_val,
  output logic [LIFE_W-1:0]       out_life,
  output logic [7:0]              drop_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_out_valid;
  logic [VAL_W-1:0]   r_out_val;
  logic [LIFE_W-1:0]  r_out_life;
  logic [7:0]         r_drop_cnt;

  logic [VAL_W-1:0]   w_head_val;
  logic [LIFE_W-1:0]  w_head_life;
  logic               w_recirc;
  logic               w_arb_en;
  logic [NREQ-1:0]    w_arb_req;
  logic [NREQ-1:0]    w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [VAL_W-1:0]   w_sel_val;
  logic [LIFE_W-1:0]  w_sel_life;
  logic               w_any_gnt;
  logic               w_drop;
  logic               w_new_enq;

  assign w_head_val  = q_dout[LIFE_W +: VAL_W];
  assign w_head_life = q_dout[LIFE_W-1:0];

  // Recirculation may write while q_full: the dequeue one edge earlier freed a slot.
  assign w_recirc  = rst && (r_state == c_st_fetch) && (w_head_life > LIFE_W'(1));
  assign w_arb_en  = rst && !q_full && !w_recirc;
  assign w_arb_req = req & {NREQ{w_arb_en}};

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (w_arb_req),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_gnt_idx  = '0;
    w_sel_val  = '0;
    w_sel_life = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_sel_val  = req_val[i*VAL_W +: VAL_W];
        w_sel_life = req_life[i*LIFE_W +: LIFE_W];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NREQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
  assign w_any_gnt = |w_gnt;
  assign w_drop    = w_any_gnt && (w_sel_life == '0);
  assign w_new_enq = w_any_gnt && !w_drop;

  assign gnt   = w_gnt;
  assign q_enq = w_recirc || w_new_enq;
  assign q_deq = rst && (r_state == c_st_idle) && !q_empty;

  always_comb begin
    q_din = '0;
    if (w_recirc)
      q_din = {w_head_val, w_head_life - LIFE_W'(1)};
    else if (w_new_enq)
      q_din = {w_sel_val, w_sel_life};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_st_idle;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_val   <= '0;
      r_out_life  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_any_gnt)
        r_ptr <= w_ptr_nxt;
      if (w_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
      case (r_state)
        c_st_idle: begin
          if (!q_empty) r_state <= c_st_fetch;
        end
        c_st_fetch: begin
          r_out_val   <= w_head_val;
          r_out_life  <= w_head_life - LIFE_W'(1);
          r_out_valid <= 1'b1;
          r_state     <= c_st_hold;
        end
        c_st_hold: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_val   = r_out_val;
  assign out_life  = r_out_life;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spike_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_queue_ctrl
// Description : Directed bench for spike_queue_ctrl with a small fifo model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_queue_ctrl;
  import spike_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_val;
  logic [63:0] req_life;
  logic [3:0]  gnt;
  logic        q_enq, q_deq;
  logic [31:0] q_din;
  logic [31:0] q_dout;
  logic        q_full, q_empty;
  logic        out_valid, out_ready;
  logic [15:0] out_val, out_life;
  logic [7:0]  drop_cnt;

  logic        force_full;
  logic [31:0] mem [8];
  logic [2:0]  wp, rp;
  logic [3:0]  cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          proto_err = 0;
  logic        seen;
  logic        bad;

  spike_queue_ctrl #(.NREQ(4), .VAL_W(16), .LIFE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_val   (req_val),
    .req_life  (req_life),
    .gnt       (gnt),
    .q_enq     (q_enq),
    .q_deq     (q_deq),
    .q_din     (q_din),
    .q_dout    (q_dout),
    .q_full    (q_full),
    .q_empty   (q_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_life  (out_life),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Eight-deep fifo with registered head read.
  assign q_full  = (cnt == 4'd8) || force_full;
  assign q_empty = (cnt == 4'd0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; cnt <= '0; q_dout <= '0;
    end else begin
      if (q_deq) begin
        q_dout <= mem[rp];
        rp     <= rp + 3'd1;
      end
      if (q_enq) begin
        mem[wp] <= q_din;
        wp      <= wp + 3'd1;
      end
      cnt <= cnt + {3'd0, q_enq} - {3'd0, q_deq};
    end
  end

  always @(negedge clk)
    if (rst && q_deq && q_empty) proto_err <= proto_err + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ent(input logic [15:0] v, input logic [15:0] l);
    spike_entry_t e;
    e.val  = v;
    e.life = l;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] v, input logic [15:0] l);
    req_val[i*16 +: 16]  = v;
    req_life[i*16 +: 16] = l;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req = '0; req_val = '0; req_life = '0;
    out_ready = 1'b0; force_full = 1'b0;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_enq", q_enq, 0);
    chk("rst_deq", q_deq, 0);
    chk("rst_din", q_din, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_oval", out_val, 0);
    chk("rst_olife", out_life, 0);
    chk("rst_drop", drop_cnt, 0);
    step();
    rst = 1'b1;

    // Single entry (42,3) circulates three times.
    set_req(0, 16'd42, 16'd3); req = 4'b0001; out_ready = 1'b1;
    #1;
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_enq", q_enq, 1);
    chk("t1_din", q_din, ent(42, 3));
    step(); req = '0;
    #1; chk("t1_deq", q_deq, 1);
    step();
    #1; chk("t1_rc_enq", q_enq, 1); chk("t1_rc_din", q_din, ent(42, 2));
    step();
    #1; chk("t1_ov1", out_valid, 1); chk("t1_val1", out_val, 42); chk("t1_life1", out_life, 2);
    step();
    #1; chk("t1_deq2", q_deq, 1);
    step();
    #1; chk("t1_rc_din2", q_din, ent(42, 1));
    step();
    #1; chk("t1_life2", out_life, 1);
    step();
    step();
    #1; chk("t1_last_noenq", q_enq, 0);
    step();
    #1; chk("t1_ov3", out_valid, 1); chk("t1_life3", out_life, 0);
    step(); step(); step();
    #1; chk("t1_idle_ov", out_valid, 0); chk("t1_idle_deq", q_deq, 0); chk("t1_fifo_cnt", cnt, 0);

    // Round-robin across four continuously requesting sources.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'(100 + i), 16'd1);
    req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1; chk("rr_gnt", gnt, 64'(4'b0001 << (k % 4)));
      step();
    end
    req = '0;

    // Back-pressure from q_full.
    do_reset();
    force_full = 1'b1; set_req(1, 16'd5, 16'd2); req = 4'b0010;
    #1; chk("full_gnt", gnt, 0); chk("full_enq", q_enq, 0);
    step();
    #1; chk("full_gnt2", gnt, 0);
    force_full = 1'b0;
    #1; chk("unfull_gnt", gnt, 4'b0010); chk("unfull_enq", q_enq, 1); chk("unfull_din", q_din, ent(5, 2));
    req = '0;
    do_reset();

    // Life-0 requests are discarded and counted with saturation.
    set_req(2, 16'd1, 16'd0); req = 4'b0100; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (q_enq) seen = 1'b1;
      if (i == 0)   chk("drop_gnt", gnt, 4'b0100);
      if (i == 10)  chk("drop_10", drop_cnt, 10);
      if (i == 256) chk("drop_sat", drop_cnt, 255);
      step();
    end
    req = '0;
    #1; chk("drop_noenq", seen, 0); chk("drop_255", drop_cnt, 255);

    // Head (7,5) held in HOLD while the consumer stalls.
    out_ready = 1'b0;
    set_req(0, 16'd7, 16'd5); req = 4'b0001;
    #1; chk("h_gnt", gnt, 4'b0001);
    step(); req = '0;
    #1; chk("h_deq", q_deq, 1);
    step();
    set_req(0, 16'd9, 16'd3); req = 4'b0001;
    #1; chk("h_fetch_gnt", gnt, 0); chk("h_fetch_enq", q_enq, 1); chk("h_fetch_din", q_din, ent(7, 4));
    step(); req = '0; bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid !== 1'b1 || out_val !== 16'd7 || out_life !== 16'd4 || q_deq !== 1'b0) bad = 1'b1;
      step();
    end
    chk("h_stable", bad, 0);
    chk("h_val", out_val, 7);
    chk("h_life", out_life, 4);
    chk("h_deq0", q_deq, 0);

    // Asynchronous reset in HOLD.
    rst = 1'b0;
    #1; chk("ar_ovalid", out_valid, 0); chk("ar_olife", out_life, 0); chk("ar_enq", q_enq, 0);
    step(); rst = 1'b1;
    #1; chk("ar_drop", drop_cnt, 0); chk("ar_deq", q_deq, 0);
    set_req(0, 16'd3, 16'd1); req = 4'b0001;
    step(); req = '0;
    #1; chk("ar_idle_deq", q_deq, 1);
    step(); step();
    #1; chk("ar_ov", out_valid, 1); chk("ar_oval", out_val, 3); chk("ar_olife2", out_life, 0);

    chk("deq_when_empty", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
